// File: rtl/irq_pending_ctrl_pkg.sv
// Shared types and helpers for the CP0 interrupt front end.
// Contents:
//   N_IRQ      - number of interrupt lines (bit N_IRQ-1 is highest priority)
//   irq_vec_t  - one bit per interrupt line
//   msb_onehot - isolates the most significant set bit of a vector
//   is_onehot  - true when exactly one bit of a vector is set
package cp0_irq_pkg;

  localparam int N_IRQ = 8;

  typedef logic [N_IRQ-1:0] irq_vec_t;

  // Scanning upward lets the highest set bit overwrite any lower one.
  function automatic irq_vec_t msb_onehot(irq_vec_t v);
    irq_vec_t r;
    r = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (v[i]) r = irq_vec_t'(1) << i;
    end
    return r;
  endfunction

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  function automatic logic is_onehot(irq_vec_t v);
    return (v != '0) && ((v & (v - irq_vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_sync.sv
// irq_sync: multi-flop synchronizer for asynchronous interrupt lines, with a
// one-cycle-delayed copy used for rising-edge detection.
// Ports:
//   clk     in   1      clock
//   rst     in   1      asynchronous active-high reset
//   d_i     in   WIDTH  raw asynchronous inputs
//   sync_o  out  WIDTH  inputs after SYNC_STAGES flops
//   rise_o  out  WIDTH  sync_o high while its delayed copy is still low
module irq_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < SYNC_STAGES; s++) stage_q[s] <= stage_q[s-1];
      prev_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign rise_o = stage_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: CP0 interrupt front end. Synchronizes raw IRQ lines,
// keeps edge/level pending state, applies the IM mask and nested
// in-service blocking, and presents eligible lines to the external
// priority encoder. The encoder's one-hot grant is taken back on acknowledge.
// Ports:
//   clk          in   1      clock
//   rst          in   1      asynchronous active-high reset
//   irq_in       in   N_IRQ  raw interrupt lines, asynchronous to clk
//   im           in   N_IRQ  Status IM field, 1 = line enabled
//   global_en    in   1      Status IE & ~EXL
//   pend_clr     in   N_IRQ  write-one-to-clear for edge pending bits
//   irq_ack      in   1      CPU takes the interrupt this cycle
//   grant        in   N_IRQ  one-hot encoder output, used with irq_ack
//   irq_eret     in   1      ERET retired
//   irq_prior    out  N_IRQ  eligible lines, to encoder prior_in
//   irq_req      out  1      interrupt request to pipeline
//   pending_out  out  N_IRQ  raw pending bits (Cause IP)
//   isr_out      out  N_IRQ  in-service bits
module irq_pending_ctrl
  import cp0_irq_pkg::*;
#(
  parameter int               N_IRQ          = cp0_irq_pkg::N_IRQ,
  parameter int               SYNC_STAGES    = 2,
  parameter logic [N_IRQ-1:0] EDGE_SENSITIVE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] im,
  input  logic             global_en,
  input  logic [N_IRQ-1:0] pend_clr,
  input  logic             irq_ack,
  input  logic [N_IRQ-1:0] grant,
  input  logic             irq_eret,
  output logic [N_IRQ-1:0] irq_prior,
  output logic             irq_req,
  output logic [N_IRQ-1:0] pending_out,
  output logic [N_IRQ-1:0] isr_out
);

  localparam irq_vec_t EDGE_MASK = irq_vec_t'(EDGE_SENSITIVE);

  irq_vec_t sync_s;
  irq_vec_t rise_s;
  irq_vec_t pend_q, pend_d;
  irq_vec_t isr_q,  isr_d;
  irq_vec_t top_s;
  irq_vec_t allow_s;
  irq_vec_t prior_s;
  irq_vec_t clr_s;
  irq_vec_t ack_vec_s;
  logic     ack_ok_s;

  irq_sync #(
    .WIDTH       (N_IRQ),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (irq_in),
    .sync_o (sync_s),
    .rise_o (rise_s)
  );

  always_comb begin
    top_s = msb_onehot(isr_q);
    // Only lines strictly above the innermost in-service level may nest.
    // When line N_IRQ-1 is in service the shift wraps to zero and the
    // subtraction yields all ones, so nothing is allowed.
    if (isr_q == '0) allow_s = '1;
    else             allow_s = ~((top_s << 1) - irq_vec_t'(1));

    prior_s = pend_q & im & allow_s;

    // A grant counts only if it is one-hot and names a line that is
    // eligible right now; anything else is dropped without side effects.
    ack_ok_s  = irq_ack & is_onehot(grant) & (|(grant & prior_s));
    ack_vec_s = ack_ok_s ? grant : '0;

    // Set has priority over clear so an edge arriving with its own ack
    // stays pending. Level lines just follow the synchronized input.
    clr_s  = pend_clr | ack_vec_s;
    pend_d = (EDGE_MASK & (rise_s | (pend_q & ~clr_s))) | (~EDGE_MASK & sync_s);

    // ERET retires the innermost level first, then a same-cycle grant is added.
    isr_d = (isr_q & ~(irq_eret ? top_s : '0)) | ack_vec_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      isr_q  <= '0;
    end else begin
      pend_q <= pend_d;
      isr_q  <= isr_d;
    end
  end

  assign irq_prior   = prior_s;
  assign irq_req     = global_en & (|prior_s);
  assign pending_out = pend_q;
  assign isr_out     = isr_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
module tb_irq_pending_ctrl;

  localparam int         S    = 2;
  localparam logic [7:0] EDGE = 8'h0F;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in, im, pend_clr, grant;
  logic       global_en, irq_ack, irq_eret;
  logic [7:0] irq_prior, pending_out, isr_out;
  logic       irq_req;

  int checks = 0;
  int errors = 0;

  irq_pending_ctrl #(
    .N_IRQ          (8),
    .SYNC_STAGES    (S),
    .EDGE_SENSITIVE (EDGE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .im          (im),
    .global_en   (global_en),
    .pend_clr    (pend_clr),
    .irq_ack     (irq_ack),
    .grant       (grant),
    .irq_eret    (irq_eret),
    .irq_prior   (irq_prior),
    .irq_req     (irq_req),
    .pending_out (pending_out),
    .isr_out     (isr_out)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Input history: smp[k] is irq_in as sampled k clock edges ago.
  // In-service levels kept as a stack of line numbers (innermost last).
  logic [7:0] smp [S+1];
  logic [7:0] pend_m = 8'h00;
  int         stk[$];
  logic [7:0] m_pr, m_syn, m_prv;
  logic       m_ack_ok;

  initial for (int k = 0; k <= S; k++) smp[k] = 8'h00;

  function automatic logic [7:0] m_allow();
    logic [7:0] a;
    a = 8'hFF;
    if (stk.size() > 0) begin
      a = 8'h00;
      for (int i = 0; i < 8; i++) if (i > stk[$]) a[i] = 1'b1;
    end
    return a;
  endfunction

  function automatic logic [7:0] m_isr();
    logic [7:0] v;
    v = 8'h00;
    foreach (stk[j]) v[stk[j]] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] m_prior();
    return pend_m & im & m_allow();
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pend_m = 8'h00;
      stk.delete();
      for (int k = 0; k <= S; k++) smp[k] = 8'h00;
    end else begin
      m_pr     = m_prior();
      m_ack_ok = irq_ack && ($countones(grant) == 1) && ((grant & m_pr) != 8'h00);
      m_syn    = smp[S-1];
      m_prv    = smp[S];
      for (int i = 0; i < 8; i++) begin
        if (EDGE[i])
          pend_m[i] = (m_syn[i] & ~m_prv[i]) |
                      (pend_m[i] & ~(pend_clr[i] | (m_ack_ok & grant[i])));
        else
          pend_m[i] = m_syn[i];
      end
      if (irq_eret && stk.size() > 0) void'(stk.pop_back());
      if (m_ack_ok) for (int i = 0; i < 8; i++) if (grant[i]) stk.push_back(i);
      for (int k = S; k >= 1; k--) smp[k] = smp[k-1];
      smp[0] = irq_in;
    end
  end

  // Compare on every falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("m_rst_pend",  pending_out, 8'h00);
        chk("m_rst_prior", irq_prior,   8'h00);
        chk("m_rst_isr",   isr_out,     8'h00);
        chk("m_rst_req",   {7'b0, irq_req}, 8'h00);
      end else begin
        chk("m_pend",  pending_out, pend_m);
        chk("m_prior", irq_prior,   m_prior());
        chk("m_isr",   isr_out,     m_isr());
        chk("m_req",   {7'b0, irq_req}, {7'b0, global_en & (m_prior() != 8'h00)});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle();
    irq_ack = 1'b0; grant = 8'h00; irq_eret = 1'b0; pend_clr = 8'h00;
  endtask

  initial begin
    rst = 1'b1; irq_in = 8'hFF; im = 8'hFF; global_en = 1'b1;
    idle();
    tick(2);
    chk("rst_pend",  pending_out, 8'h00);
    chk("rst_prior", irq_prior,   8'h00);
    chk("rst_isr",   isr_out,     8'h00);
    chk("rst_req",   {7'b0, irq_req}, 8'h00);

    rst = 1'b0;
    tick(2);
    chk("lat_clk2_pend", pending_out, 8'h00);
    tick(1);
    chk("lat_clk3_pend",  pending_out, 8'hFF);
    chk("lat_clk3_prior", irq_prior,   8'hFF);
    chk("lat_clk3_req",   {7'b0, irq_req}, 8'h01);

    irq_in = 8'h00; pend_clr = 8'h0F;
    tick(1); idle(); tick(3);
    chk("cleanup_pend", pending_out, 8'h00);

    // Edge line 3 pulse and ack
    irq_in = 8'h08; tick(1); irq_in = 8'h00; tick(1);
    chk("edge_clk2_pend", pending_out, 8'h00);
    tick(1);
    chk("edge_clk3_pend",  pending_out, 8'h08);
    chk("edge_clk3_prior", irq_prior,   8'h08);
    irq_ack = 1'b1; grant = 8'h08; tick(1); idle();
    chk("edge_ack_pend",  pending_out, 8'h00);
    chk("edge_ack_isr",   isr_out,     8'h08);
    chk("edge_ack_prior", irq_prior,   8'h00);

    // Nesting with isr=08
    irq_in = 8'h22; tick(3);
    chk("nest_prior", irq_prior,   8'h20);
    chk("nest_pend",  pending_out, 8'h22);
    irq_ack = 1'b1; grant = 8'h20; tick(1); idle();
    chk("nest_isr28", isr_out, 8'h28);
    chk("nest_prior28", irq_prior, 8'h00);
    irq_eret = 1'b1; tick(1); idle();
    chk("nest_eret1_isr", isr_out, 8'h08);
    irq_eret = 1'b1; tick(1); idle();
    chk("nest_eret2_isr",   isr_out,   8'h00);
    chk("nest_eret2_prior", irq_prior, 8'h22);
    irq_in = 8'h00; tick(3);
    pend_clr = 8'h02; tick(1); idle();
    chk("nest_clean_pend", pending_out, 8'h00);

    // Edge arriving together with its own ack
    irq_in = 8'h04; tick(1); irq_in = 8'h00; tick(2);
    chk("coll_first_pend", pending_out, 8'h04);
    irq_in = 8'h04; tick(1); irq_in = 8'h00; tick(1);
    irq_ack = 1'b1; grant = 8'h04; tick(1); idle();
    chk("coll_pend", pending_out, 8'h04);
    chk("coll_isr",  isr_out,     8'h04);
    irq_eret = 1'b1; tick(1); idle();
    pend_clr = 8'h04; tick(1); idle();
    chk("coll_clean_pend", pending_out, 8'h00);
    chk("coll_clean_isr",  isr_out,     8'h00);

    // Bad grants
    irq_in = 8'h80; tick(3);
    chk("bad_prior", irq_prior, 8'h80);
    irq_ack = 1'b1; grant = 8'h30; tick(1); idle();
    chk("bad30_pend", pending_out, 8'h80);
    chk("bad30_isr",  isr_out,     8'h00);
    irq_ack = 1'b1; grant = 8'h01; tick(1); idle();
    chk("bad01_pend", pending_out, 8'h80);
    chk("bad01_isr",  isr_out,     8'h00);
    irq_in = 8'hA0; tick(3);
    chk("pre_swap_prior", irq_prior, 8'hA0);
    irq_ack = 1'b1; grant = 8'h20; tick(1); idle();
    chk("pre_swap_isr",  isr_out,   8'h20);
    chk("pre_swap_pr80", irq_prior, 8'h80);
    irq_eret = 1'b1; irq_ack = 1'b1; grant = 8'h80; tick(1); idle();
    chk("eret_ack_isr", isr_out, 8'h80);
    irq_eret = 1'b1; tick(1); idle();
    chk("eret_last_isr", isr_out, 8'h00);

    // Masking
    im = 8'h00; #1;
    chk("mask_prior", irq_prior,   8'h00);
    chk("mask_pend",  pending_out, 8'hA0);
    chk("mask_req",   {7'b0, irq_req}, 8'h00);
    irq_in = 8'hB0; tick(3);
    im = 8'h10; global_en = 1'b0; #1;
    chk("gen0_prior", irq_prior, 8'h10);
    chk("gen0_req",   {7'b0, irq_req}, 8'h00);
    global_en = 1'b1; #1;
    chk("gen1_req",   {7'b0, irq_req}, 8'h01);
    im = 8'hFF; irq_in = 8'hB8; tick(1); irq_in = 8'hB0; tick(2);
    chk("clr_before", pending_out, 8'hB8);
    pend_clr = 8'h08; tick(1); idle();
    chk("clr_after", pending_out, 8'hB0);

    // Reset in the middle of a handshake
    rst = 1'b1; #1;
    chk("rst_async_pend", pending_out, 8'h00);
    tick(1);
    rst = 1'b0; irq_ack = 1'b1; grant = 8'h80; tick(1); idle();
    chk("rst_grant_isr",  isr_out,     8'h00);
    chk("rst_grant_pend", pending_out, 8'h00);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
